switch_event_ctrl: RTL and testbench
====================================

# switch_event_ctrl

Memory-mapped input controller for the three push switches on the board. It debounces the raw switch pins and turns each press into a 2-bit event code. Codes are queued in a small FIFO so the processor can read them one at a time without losing presses. It sits between the switch pins and the processor's read bus, decoded in the `addr[23]` I/O region.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `DB_TICKS`, 8: consecutive `tick_en` samples a changed level must hold before it is accepted; 2..255.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `clr`  in  1  reset; synchronous, active-high.
- `tick_en`  in  1  one-cycle debounce sample strobe, e.g. 1 kHz.
- `rd_en`  in  1  processor read strobe; one cycle per access.
- `addr`  in  32  processor address.
- `switches`  in  3  raw asynchronous switch pins; 1 = pressed.
- `rd_data`  out  32  registered read data.
- `irq`  out  1  registered; high while the FIFO is non-empty.
- `overflow`  out  1  sticky flag: a press was dropped because the FIFO was full.

## Operation
- **Synchronizer.** Each `switches` bit passes through a 2-flop synchronizer, reset to 0.
- **Debounce**, per switch, evaluated only on cycles with `tick_en`=1:
  - If the synchronized level equals the stable state, the counter is cleared.
  - Otherwise the counter increments.
  - When the counter reaches `DB_TICKS`-1 on a differing sample, the stable state flips and the counter clears.
  - Counter width is 8 bits.
- **Press detection.** A stable 0->1 transition sets that switch's pending bit. A 1->0 transition (release) generates nothing.
- **Encoder.**
  - Each cycle, the lowest-index set pending bit is pushed as its code and then cleared. Codes: switch0=2'b01, switch1=2'b10, switch2=2'b11.
  - Simultaneous presses are therefore pushed on consecutive cycles in index order.
  - A pending bit set in the same cycle it is already set stays set. Repeat presses before service merge.
- **Address decode.** A valid access requires `rd_en`=1 and `addr[23]`=1.
  - `addr[2:0]`=3'b001, DATA: `rd_data` = {30'b0, head code}, and the head is popped. If the FIFO is empty, `rd_data` = 0 and no pop occurs.
  - `addr[2:0]`=3'b010, STATUS: `rd_data` = {23'b0, overflow, 3'b0, count[4:0]}. This read also clears `overflow`.
  - Any other address: `rd_data` is unchanged and there are no side effects.
- **FIFO boundaries.**
  - Push while full with no pop in the same cycle: the code is dropped, its pending bit is still cleared, and `overflow` is set.
  - Push while full together with a DATA pop: both happen, and the count is unchanged.
  - Push into an empty FIFO together with a DATA read: the read returns 0. The pushed code is visible on the next read.
  - Read and write pointers wrap modulo `DEPTH`. Count is `$clog2(DEPTH)+1` bits, zero-extended to 5 bits in STATUS.
- **Overflow set vs. clear.** A STATUS read clears `overflow` in the same cycle unless an overflow drop also occurs in that cycle; set wins.

## Timing
- **Reset.** `clr` sampled high at a `clk` edge resets everything:
  - Synchronizers, stable states, counters, pending bits, pointers and count go to 0.
  - `rd_data`=0, `irq`=0, `overflow`=0.
  - Reset mid-operation discards queued and pending events.
- **Read latency.** `rd_data` is valid the cycle after the `rd_en` edge and holds until the next valid access.
- **Push latency.** A stable-state flip at edge N sets pending at edge N. The push occurs at edge N+1. `irq` rises at edge N+2.
- **Press latency.** A press lands in the FIFO about `DB_TICKS` ticks plus 2 synchronizer cycles plus 2 cycles after the pin settles.
- **irq timing.** `irq` falls the cycle after the pop that empties the FIFO.
- **Back-to-back reads.** `rd_en` may be asserted every cycle. Each DATA read pops at most one entry.

## Structure
- Package `switch_event_pkg` holds:
  - address-offset constants `SW_DATA_OFS`=3'b001 and `SW_STAT_OFS`=3'b010, plus the I/O region bit index 23;
  - code constants `SW_CODE_NONE`/`SW0`/`SW1`/`SW2`;
  - STATUS bit positions.
- Sub-module `switch_debounce` implements synchronizer, counter and stable state for one switch. It has parameter `DB_TICKS` and outputs `stable` and `rise`. The block instantiates it 3 times.
- The FIFO, encoder and read decode stay inline.

## Test plan
- **Single press.** Hold switch1 for 10 ticks (`DB_TICKS`=8) -> `irq` rises; DATA read returns 2 and `irq` falls; a second DATA read returns 0.
- **Bounce.** switch0 toggles every 3 ticks for 30 ticks, then holds high -> exactly one event (code 1). No event while it bounces.
- **Simultaneous press.** All three switches rise together -> three DATA reads return 1, 2, 3 in that order; STATUS count reads 3 before the first DATA read.
- **Overflow.** `DEPTH`=4; six distinct presses with no reads -> STATUS returns count 4 with bit 8 set; a second STATUS read has bit 8 clear; DATA reads return the first four codes.
- **Full plus read.** FIFO full, a DATA read lands in the same cycle as a new push -> count stays 4, `overflow` stays 0, FIFO order is preserved across pointer wrap.
- **Reset mid-operation.** `clr` asserted with 2 queued events and a pending bit set -> next cycle `irq`=0 and `rd_data`=0; STATUS read returns 0.

Source files
------------

// File: rtl/switch_event_pkg.sv
// Shared constants for the push-switch event controller: bus offsets, event
// codes and STATUS register layout.
package switch_event_pkg;

  localparam int SW_IO_BIT = 23;

  localparam logic [2:0] SW_DATA_OFS = 3'b001;
  localparam logic [2:0] SW_STAT_OFS = 3'b010;

  typedef enum logic [1:0] {
    SW_CODE_NONE = 2'b00,
    SW_CODE_SW0  = 2'b01,
    SW_CODE_SW1  = 2'b10,
    SW_CODE_SW2  = 2'b11
  } sw_code_e;

  localparam int STAT_CNT_LSB = 0;
  localparam int STAT_CNT_W   = 5;
  localparam int STAT_OVF_BIT = 8;

  // Switch index 0..2 maps to code 1..3.
  function automatic sw_code_e sw_code_of(input logic [1:0] idx);
    return sw_code_e'(idx + 2'd1);
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// One switch channel: 2-flop synchronizer, tick-sampled debounce counter and
// stable level, with a single-cycle rise indication aligned to the flip.
module switch_debounce
  import switch_event_pkg::*;
#(
  parameter int DB_TICKS = 8
) (
  input  logic clk,
  input  logic clr,
  input  logic tick_en,
  input  logic sw_in,
  output logic stable,
  output logic rise
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       stable_q, stable_d;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = sw_in;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (tick_en) begin
      if (sync2_q == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == 8'(DB_TICKS - 1)) begin
        stable_d = ~stable_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Rise is combinational so the press registers on the same edge as the flip.
  assign stable = stable_q;
  assign rise   = stable_d & ~stable_q;

endmodule

// File: rtl/switch_event_ctrl.sv
// Memory-mapped push-switch controller: debounces three switches, encodes
// presses and queues the codes in a FIFO read through DATA/STATUS registers.
module switch_event_ctrl
  import switch_event_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int DB_TICKS = 8
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        tick_en,
  input  logic        rd_en,
  input  logic [31:0] addr,
  input  logic [2:0]  switches,
  output logic [31:0] rd_data,
  output logic        irq,
  output logic        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2:0] stable_w;
  logic [2:0] rise_w;

  for (genvar i = 0; i < 3; i++) begin : g_db
    switch_debounce #(.DB_TICKS(DB_TICKS)) u_db (
      .clk     (clk),
      .clr     (clr),
      .tick_en (tick_en),
      .sw_in   (switches[i]),
      .stable  (stable_w[i]),
      .rise    (rise_w[i])
    );
  end

  logic [2:0]    pending_q, pending_d;
  logic [1:0]    mem_q [DEPTH];
  logic [1:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          irq_q, irq_d;
  logic          overflow_q, overflow_d;

  logic     push_valid, push_ok, drop, pop;
  logic     access, data_rd, stat_rd;
  logic     fifo_full, fifo_empty;
  logic [2:0] clr_mask;
  sw_code_e push_code;

  always_comb begin
    push_valid = |pending_q;
    push_code  = SW_CODE_NONE;
    clr_mask   = 3'b000;
    if (pending_q[0]) begin
      push_code = sw_code_of(2'd0);
      clr_mask  = 3'b001;
    end else if (pending_q[1]) begin
      push_code = sw_code_of(2'd1);
      clr_mask  = 3'b010;
    end else if (pending_q[2]) begin
      push_code = sw_code_of(2'd2);
      clr_mask  = 3'b100;
    end

    access     = rd_en & addr[SW_IO_BIT];
    data_rd    = access && (addr[2:0] == SW_DATA_OFS);
    stat_rd    = access && (addr[2:0] == SW_STAT_OFS);
    fifo_full  = (count_q == CW'(DEPTH));
    fifo_empty = (count_q == '0);

    // A full FIFO still accepts the push when a pop frees a slot this cycle.
    pop     = data_rd & ~fifo_empty;
    push_ok = push_valid & (~fifo_full | pop);
    drop    = push_valid & fifo_full & ~pop;

    pending_d = (pending_q & ~clr_mask) | rise_w;

    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = push_code;
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop);

    rd_data_d = rd_data_q;
    if (data_rd) begin
      rd_data_d = pop ? {30'd0, mem_q[rd_ptr_q]} : 32'd0;
    end else if (stat_rd) begin
      rd_data_d = 32'd0;
      rd_data_d[STAT_OVF_BIT] = overflow_q;
      rd_data_d[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(count_q);
    end

    overflow_d = drop | (overflow_q & ~stat_rd);
    irq_d      = ~fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pending_q  <= '0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      irq_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      irq_q      <= irq_d;
      overflow_q <= overflow_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign irq      = irq_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_switch_event_ctrl.sv
// Self-checking bench for switch_event_ctrl: directed vector table, corner
// sequences and random traffic against a queue-based reference model.
module tb_switch_event_ctrl;

  localparam int DEPTH    = 4;
  localparam int DB_TICKS = 8;
  localparam int TICK_DIV = 4;
  localparam logic [31:0] A_DATA = 32'h0080_0001;
  localparam logic [31:0] A_STAT = 32'h0080_0002;

  logic        clk;
  logic        clr;
  logic        tick_en;
  logic        rd_en;
  logic [31:0] addr;
  logic [2:0]  switches;
  logic [31:0] rd_data;
  logic        irq;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 0;

  switch_event_ctrl #(.DEPTH(DEPTH), .DB_TICKS(DB_TICKS)) dut (
    .clk      (clk),
    .clr      (clr),
    .tick_en  (tick_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .switches (switches),
    .rd_data  (rd_data),
    .irq      (irq),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Debounce strobe every TICK_DIV cycles
  initial begin
    int tick_cnt;
    tick_cnt = 0;
    tick_en  = 1'b0;
    forever begin
      @(negedge clk);
      tick_cnt++;
      tick_en = (tick_cnt % TICK_DIV == 0);
    end
  end

  // Reference model: a press is accepted once the last DB_TICKS tick samples
  // all disagree with the stable level; codes live in a plain queue.
  logic [2:0]   m_h1, m_h2, m_stable, m_pend;
  logic [255:0] m_win [3];
  int           m_wcnt [3];
  logic [1:0]   mq [$];
  logic         m_ovf, m_irq;
  logic [31:0]  m_rd;

  always @(posedge clk) begin : model
    int sz;
    bit popd, stat, drop;
    logic [255:0] mask;
    if (clr) begin
      m_h1 = '0; m_h2 = '0; m_stable = '0; m_pend = '0;
      for (int s = 0; s < 3; s++) begin
        m_win[s]  = '0;
        m_wcnt[s] = 0;
      end
      mq.delete();
      m_ovf = 1'b0; m_irq = 1'b0; m_rd = '0;
    end else begin
      sz = mq.size(); popd = 0; stat = 0; drop = 0;
      if (rd_en && addr[23]) begin
        if (addr[2:0] == 3'b001) begin
          if (sz > 0) begin
            m_rd = {30'd0, mq.pop_front()};
            popd = 1;
          end else begin
            m_rd = '0;
          end
        end else if (addr[2:0] == 3'b010) begin
          m_rd = (32'(m_ovf) << 8) | 32'(sz);
          stat = 1;
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (m_pend[i]) begin
          if (sz < DEPTH || popd) mq.push_back(2'(i + 1));
          else drop = 1;
          m_pend[i] = 1'b0;
          break;
        end
      end
      if (stat) m_ovf = 1'b0;
      if (drop) m_ovf = 1'b1;
      m_irq = (sz != 0);
      mask = (256'd1 << DB_TICKS) - 256'd1;
      if (tick_en) begin
        for (int s = 0; s < 3; s++) begin
          m_win[s] = {m_win[s][254:0], m_h2[s]};
          if (m_wcnt[s] < 255) m_wcnt[s]++;
          if (m_wcnt[s] >= DB_TICKS &&
              (m_win[s] & mask) == (m_stable[s] ? 256'd0 : mask)) begin
            m_stable[s] = ~m_stable[s];
            if (m_stable[s]) m_pend[s] = 1'b1;
          end
        end
      end
      m_h2 = m_h1;
      m_h1 = switches;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("mon_rd_data", rd_data, m_rd);
      checkOutput("mon_irq", 32'(irq), 32'(m_irq));
      checkOutput("mon_overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic applyStimulus(input logic [2:0] sw, input logic rd, input logic [31:0] a);
    @(negedge clk);
    switches = sw;
    rd_en    = rd;
    addr     = a;
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
    applyStimulus(switches, 1'b1, a);
    applyStimulus(switches, 1'b0, 32'h0);
    d = rd_data;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * TICK_DIV) @(negedge clk);
  endtask

  task automatic press_release(input logic [2:0] sw);
    applyStimulus(sw, 1'b0, 32'h0);
    wait_ticks(12);
    applyStimulus(3'b000, 1'b0, 32'h0);
    wait_ticks(12);
  endtask

  // Waits (bounded) until the model holds a pending press that pushes next edge.
  task automatic wait_pending(output bit ok);
    ok = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (m_pend != 3'b000) begin
        ok = 1;
        break;
      end
    end
    if (!ok) checkOutput("pending_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [2:0] mask;
    int         n;
    logic [1:0] c0, c1, c2;
  } vec_t;

  vec_t vecs [5];

  initial begin : main
    logic [31:0] d;
    logic [1:0]  code;
    logic [2:0]  rsw;
    int          hold, sel;
    bit          ok;
    logic [2:0]  ovf_seq [6];

    clr = 1'b1; rd_en = 1'b0; addr = '0; switches = '0;
    @(negedge clk);
    mon_en = 1;
    checkOutput("reset_rd_data", rd_data, 32'd0);
    checkOutput("reset_irq", 32'(irq), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    clr = 1'b0;

    vecs[0] = '{3'b010, 1, 2'd2, 2'd0, 2'd0};
    vecs[1] = '{3'b001, 1, 2'd1, 2'd0, 2'd0};
    vecs[2] = '{3'b111, 3, 2'd1, 2'd2, 2'd3};
    vecs[3] = '{3'b101, 2, 2'd1, 2'd3, 2'd0};
    vecs[4] = '{3'b110, 2, 2'd2, 2'd3, 2'd0};

    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].mask, 1'b0, 32'h0);
      wait_ticks(12);
      checkOutput("vec_irq_high", 32'(irq), 32'd1);
      read_reg(A_STAT, d);
      checkOutput("vec_status", d, 32'(vecs[v].n));
      for (int k = 0; k < vecs[v].n; k++) begin
        code = (k == 0) ? vecs[v].c0 : (k == 1) ? vecs[v].c1 : vecs[v].c2;
        read_reg(A_DATA, d);
        checkOutput("vec_data", d, {30'd0, code});
      end
      read_reg(A_DATA, d);
      checkOutput("vec_data_empty", d, 32'd0);
      repeat (2) @(negedge clk);
      checkOutput("vec_irq_low", 32'(irq), 32'd0);
      applyStimulus(3'b000, 1'b0, 32'h0);
      wait_ticks(12);
    end

    // Bounce: levels held 3 ticks never qualify, then a steady hold does
    for (int t = 0; t < 10; t++) begin
      applyStimulus((t % 2 == 0) ? 3'b001 : 3'b000, 1'b0, 32'h0);
      wait_ticks(3);
    end
    read_reg(A_STAT, d);
    checkOutput("bounce_no_event", d, 32'd0);
    applyStimulus(3'b001, 1'b0, 32'h0);
    wait_ticks(12);
    read_reg(A_STAT, d);
    checkOutput("bounce_one_event", d, 32'd1);
    read_reg(A_DATA, d);
    checkOutput("bounce_code", d, 32'd1);
    read_reg(A_DATA, d);
    checkOutput("bounce_empty", d, 32'd0);
    applyStimulus(3'b000, 1'b0, 32'h0);
    wait_ticks(12);

    // Overflow: six presses into a four-entry FIFO
    ovf_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    for (int p = 0; p < 6; p++) press_release(ovf_seq[p]);
    read_reg(A_STAT, d);
    checkOutput("ovf_status_set", d, 32'h0000_0104);
    read_reg(A_STAT, d);
    checkOutput("ovf_status_clr", d, 32'h0000_0004);
    for (int k = 0; k < 4; k++) begin
      read_reg(A_DATA, d);
      checkOutput("ovf_data", d, 32'((k % 3) + 1));
    end
    read_reg(A_DATA, d);
    checkOutput("ovf_empty", d, 32'd0);

    // Full FIFO: a DATA pop lands on the same edge as a new push
    press_release(3'b001);
    press_release(3'b010);
    press_release(3'b100);
    press_release(3'b001);
    read_reg(A_STAT, d);
    checkOutput("full_status", d, 32'h0000_0004);
    applyStimulus(3'b010, 1'b0, 32'h0);
    wait_pending(ok);
    rd_en = 1'b1;
    addr  = A_DATA;
    @(negedge clk);
    rd_en = 1'b0;
    addr  = 32'h0;
    checkOutput("full_pop_head", rd_data, 32'd1);
    applyStimulus(3'b000, 1'b0, 32'h0);
    wait_ticks(12);
    read_reg(A_STAT, d);
    checkOutput("full_push_status", d, 32'h0000_0004);
    for (int k = 0; k < 4; k++) begin
      code = (k == 0) ? 2'd2 : (k == 1) ? 2'd3 : (k == 2) ? 2'd1 : 2'd2;
      read_reg(A_DATA, d);
      checkOutput("full_order", d, {30'd0, code});
    end
    read_reg(A_DATA, d);
    checkOutput("full_empty", d, 32'd0);

    // Reset with two queued events and a pending press
    press_release(3'b001);
    press_release(3'b010);
    read_reg(A_STAT, d);
    checkOutput("rst_pre_status", d, 32'd2);
    applyStimulus(3'b100, 1'b0, 32'h0);
    wait_pending(ok);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checkOutput("rst_irq", 32'(irq), 32'd0);
    checkOutput("rst_rd_data", rd_data, 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    read_reg(A_STAT, d);
    checkOutput("rst_status", d, 32'd0);
    applyStimulus(3'b000, 1'b0, 32'h0);
    wait_ticks(12);

    // Random traffic, checked by the per-cycle monitor
    repeat (150) begin
      rsw  = 3'($urandom);
      hold = $urandom_range(1, 16) * TICK_DIV;
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        switches = rsw;
        if ($urandom_range(0, 3) == 0) begin
          rd_en = 1'b1;
          sel = $urandom_range(0, 4);
          case (sel)
            0, 1:    addr = A_DATA;
            2:       addr = A_STAT;
            3:       addr = $urandom | 32'h0080_0000;
            default: addr = ($urandom & 32'hFF7F_FFF8) | 32'h1;
          endcase
        end else begin
          rd_en = 1'b0;
        end
      end
    end
    rd_en = 1'b0;
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
